// File: rtl/digital_timer_ctrl.sv
// Stopwatch control sequencer: button conditioning, idle/run/stop/lap FSM, lap snapshot display.
// Optional debouncer enabled by defining DIGITAL_TIMER_CTRL_DEBOUNCE_EN.
module digital_timer_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int RESET_HOLD_CYCLES = 2
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            btn_start_stop,
  input  logic            btn_lap_reset,
  input  logic [5:0][6:0] clock_digits_in,
  output logic            timer_pause,
  output logic            timer_clear,
  output logic            timer_reset,
  output logic [5:0][6:0] display_out,
  output logic            lap_active,
  output logic [1:0]      ctrl_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_e;

  localparam logic [5:0][6:0] ZERO_GLYPHS = {6{7'b0000001}};
  localparam logic [3:0]      HOLD_LOAD   = 4'(RESET_HOLD_CYCLES);

  // Bit 0 carries start/stop, bit 1 carries lap/reset through the whole button path.
  logic [1:0] sync1_q, sync2_q, level, prev_q, ev_q;
  logic       ev_ss, ev_lr;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_lap_reset, btn_start_stop};
      sync2_q <= sync1_q;
    end
  end

`ifdef DIGITAL_TIMER_CTRL_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0][7:0] db_cnt_q;
  logic [1:0]      db_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_q     <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_LAST) begin
          db_q[b]     <= sync2_q[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + 8'd1;
        end
      end
    end
  end

  assign level = db_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign level = sync2_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prev_q <= '0;
      ev_q   <= '0;
    end else begin
      prev_q <= level;
      ev_q   <= level & ~prev_q;
    end
  end

  assign ev_ss = ev_q[0];
  assign ev_lr = ev_q[1];

  state_e          state_q, state_d;
  logic            clear_d, rst_req, snap_en;
  logic            pause_q, clear_q, lap_q;
  logic [3:0]      rst_cnt_q;
  logic [5:0][6:0] snap_q, disp_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    rst_req = 1'b0;
    snap_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_ss) begin
          state_d = RUN;
          clear_d = 1'b1;
        end else if (ev_lr) begin
          rst_req = 1'b1;
        end
      end
      RUN: begin
        if (ev_ss) begin
          state_d = STOP;
        end else if (ev_lr) begin
          state_d = LAP;
          snap_en = 1'b1;
        end
      end
      LAP: begin
        if (ev_ss)      state_d = STOP;
        else if (ev_lr) state_d = RUN;
      end
      STOP: begin
        if (ev_ss) begin
          state_d = RUN;
        end else if (ev_lr) begin
          state_d = IDLE;
          rst_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pause_q   <= 1'b1;
      clear_q   <= 1'b0;
      lap_q     <= 1'b0;
      rst_cnt_q <= HOLD_LOAD;
      snap_q    <= ZERO_GLYPHS;
      disp_q    <= ZERO_GLYPHS;
    end else begin
      state_q <= state_d;
      pause_q <= (state_d == IDLE) || (state_d == STOP);
      clear_q <= clear_d;
      lap_q   <= (state_d == LAP);
      if (snap_en) snap_q <= clock_digits_in;
      if (rst_req)                rst_cnt_q <= HOLD_LOAD;
      else if (rst_cnt_q != 4'd0) rst_cnt_q <= rst_cnt_q - 4'd1;
      // On entry to LAP the live digits equal the value just captured into the snapshot.
      disp_q <= (state_q == LAP && state_d == LAP) ? snap_q : clock_digits_in;
    end
  end

  assign ctrl_state  = state_q;
  assign timer_pause = pause_q;
  assign timer_clear = clear_q;
  assign timer_reset = (rst_cnt_q != 4'd0);
  assign lap_active  = lap_q;
  assign display_out = disp_q;

endmodule

// File: tb/tb_digital_timer_ctrl.sv
// Scoreboard bench for digital_timer_ctrl: directed button sequences, expectations queued per cycle.
module tb_digital_timer_ctrl;

`ifdef DIGITAL_TIMER_CTRL_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 4 + DB;
  localparam int HOLD = LAT + 2;

  localparam int S_ST = 0, S_PAUSE = 1, S_CLR = 2, S_TRST = 3, S_LAP = 4, S_DISP = 5;
  localparam logic [41:0] ZERO = {6{7'b0000001}};

  typedef struct {
    int          cyc;
    int          sel;
    logic [41:0] val;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            btn_ss, btn_lr;
  logic [5:0][6:0] digits;
  logic            timer_pause, timer_clear, timer_reset, lap_active;
  logic [5:0][6:0] display_out;
  logic [1:0]      ctrl_state;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  digital_timer_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_HOLD_CYCLES(2)) dut (
    .sys_clk        (clk),
    .rst            (rst),
    .btn_start_stop (btn_ss),
    .btn_lap_reset  (btn_lr),
    .clock_digits_in(digits),
    .timer_pause    (timer_pause),
    .timer_clear    (timer_clear),
    .timer_reset    (timer_reset),
    .display_out    (display_out),
    .lap_active     (lap_active),
    .ctrl_state     (ctrl_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [41:0] mk(int base);
    logic [5:0][6:0] d;
    for (int i = 0; i < 6; i++) d[i] = 7'((base + 7 * i) % 128);
    return d;
  endfunction

  function automatic logic [41:0] actual(int sel);
    case (sel)
      S_ST:    return 42'(ctrl_state);
      S_PAUSE: return 42'(timer_pause);
      S_CLR:   return 42'(timer_clear);
      S_TRST:  return 42'(timer_reset);
      S_LAP:   return 42'(lap_active);
      default: return display_out;
    endcase
  endfunction

  task automatic exp(int d, int sel, logic [41:0] v, string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic ss, logic lr, int hold);
    btn_ss = ss;
    btn_lr = lr;
    step(hold);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  // Monitor: compares every queued expectation that falls due on this cycle.
  always @(negedge clk) begin
    logic [41:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = actual(sb[i].sel);
        n_checks++;
        if (sb[i].cyc == cyc && act === sb[i].val) n_pass++;
        else $display("FAIL %s cyc=%0d (due %0d): got %h, expected %h",
                      sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    digits = mk(10);
    step(1);

    // Reset release
    exp(2, S_ST, 0, "rst_state");
    exp(2, S_PAUSE, 1, "rst_pause");
    exp(2, S_CLR, 0, "rst_clear");
    exp(2, S_LAP, 0, "rst_lap");
    exp(2, S_TRST, 1, "rst_treset_held");
    exp(2, S_DISP, ZERO, "rst_display");
    exp(3, S_TRST, 1, "rst_treset_1");
    exp(3, S_DISP, mk(10), "disp_after_rst");
    exp(4, S_TRST, 0, "rst_treset_done");
    step(2);
    rst = 1'b0;
    step(3);

    // IDLE -> RUN with clear pulse
    exp(LAT - 1, S_ST, 0, "start_not_early");
    exp(LAT, S_ST, 1, "start_run");
    exp(LAT, S_CLR, 1, "start_clear");
    exp(LAT, S_PAUSE, 0, "start_pause");
    exp(LAT + 1, S_CLR, 0, "clear_one_cycle");
    exp(LAT + 1, S_ST, 1, "held_one_event");
    press(1'b1, 1'b0, 10);
    step(LAT + 2);

    digits = mk(20);
    exp(1, S_DISP, mk(20), "disp_track_a");
    step(1);
    digits = mk(30);
    exp(1, S_DISP, mk(30), "disp_track_b");
    step(2);

    // RUN -> STOP, STOP -> RUN without clear
    exp(LAT, S_ST, 2, "stop_state");
    exp(LAT, S_PAUSE, 1, "stop_pause");
    press(1'b1, 1'b0, HOLD);
    step(LAT + 2);
    exp(LAT, S_ST, 1, "resume_run");
    exp(LAT, S_CLR, 0, "resume_no_clear");
    exp(LAT, S_PAUSE, 0, "resume_pause");
    press(1'b1, 1'b0, HOLD);
    step(LAT + 2);

    // Lap snapshot holds while live digits change
    digits = mk(40);
    exp(LAT, S_ST, 3, "lap_state");
    exp(LAT, S_LAP, 1, "lap_active");
    exp(LAT, S_PAUSE, 0, "lap_pause");
    exp(LAT, S_DISP, mk(40), "lap_disp_0");
    exp(LAT + 1, S_DISP, mk(40), "lap_disp_1");
    exp(LAT + 2, S_DISP, mk(40), "lap_disp_2");
    btn_lr = 1'b1;
    step(LAT);
    digits = mk(50);
    step(1);
    digits = mk(60);
    step(HOLD - LAT - 1);
    btn_lr = 1'b0;
    step(LAT + 2);

    digits = mk(70);
    exp(LAT, S_ST, 1, "unlap_state");
    exp(LAT, S_LAP, 0, "unlap_active");
    exp(LAT, S_DISP, mk(70), "unlap_disp_0");
    exp(LAT + 2, S_DISP, mk(80), "unlap_disp_1");
    btn_lr = 1'b1;
    step(LAT);
    digits = mk(80);
    step(2);
    btn_lr = 1'b0;
    step(LAT + 2);

    // Simultaneous events: start/stop wins
    exp(LAT, S_ST, 2, "both_stop");
    exp(LAT, S_LAP, 0, "both_no_lap");
    exp(LAT, S_PAUSE, 1, "both_pause");
    exp(LAT + 1, S_ST, 2, "both_stays");
    press(1'b1, 1'b1, HOLD);
    step(LAT + 2);

    // STOP -> IDLE with timer_reset pulse
    exp(LAT - 1, S_TRST, 0, "stop_rst_pre");
    exp(LAT, S_ST, 0, "stop_to_idle");
    exp(LAT, S_TRST, 1, "stop_rst_0");
    exp(LAT + 1, S_TRST, 1, "stop_rst_1");
    exp(LAT + 2, S_TRST, 0, "stop_rst_end");
    press(1'b0, 1'b1, HOLD);
    step(LAT + 2);

    // IDLE lap/reset: stay in IDLE, pulse again
    exp(LAT, S_ST, 0, "idle_rst_state");
    exp(LAT, S_TRST, 1, "idle_rst_0");
    exp(LAT + 2, S_TRST, 0, "idle_rst_end");
    press(1'b0, 1'b1, HOLD);
    step(LAT + 2);

    // IDLE -> RUN -> LAP -> STOP -> RUN -> LAP, then reset mid-lap
    exp(LAT, S_ST, 1, "seq_run");
    press(1'b1, 1'b0, HOLD);
    step(LAT + 2);
    exp(LAT, S_ST, 3, "seq_lap");
    press(1'b0, 1'b1, HOLD);
    step(LAT + 2);
    exp(LAT, S_ST, 2, "lap_to_stop");
    exp(LAT, S_LAP, 0, "lap_to_stop_lap");
    press(1'b1, 1'b0, HOLD);
    step(LAT + 2);
    exp(LAT, S_ST, 1, "seq_run2");
    press(1'b1, 1'b0, HOLD);
    step(LAT + 2);
    exp(LAT, S_ST, 3, "seq_lap2");
    press(1'b0, 1'b1, HOLD);
    step(LAT + 2);

    digits = mk(90);
    rst    = 1'b1;
    exp(1, S_ST, 0, "midrst_state");
    exp(1, S_LAP, 0, "midrst_lap");
    exp(1, S_DISP, ZERO, "midrst_disp");
    exp(1, S_PAUSE, 1, "midrst_pause");
    exp(1, S_TRST, 1, "midrst_treset_0");
    exp(2, S_TRST, 1, "midrst_treset_1");
    exp(2, S_DISP, mk(90), "midrst_disp_live");
    exp(3, S_TRST, 0, "midrst_treset_end");
    step(1);
    rst = 1'b0;
    step(4);

`ifdef DIGITAL_TIMER_CTRL_DEBOUNCE_EN
    // Short glitch rejected, longer press accepted
    exp(LAT + 2, S_ST, 0, "glitch_idle_a");
    exp(LAT + 6, S_ST, 0, "glitch_idle_b");
    press(1'b1, 1'b0, 3);
    step(LAT + 4);
    exp(LAT - 1, S_ST, 0, "db_not_early");
    exp(LAT, S_ST, 1, "db_run");
    exp(LAT, S_CLR, 1, "db_clear");
    press(1'b1, 1'b0, 5);
    step(LAT + 2);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
